// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: the carry chain is cut into STAGES equal
// segments, one resolved per clock, behind a valid/ready handshake with a global stall.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             cout_1,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_bb;
  logic             w_c0;

  assign w_bb  = sub ? ~b : b;
  assign w_c0  = cin ^ sub;
  assign w_adv = ~out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k sees only operand bits from k*SEG upward, LSB-aligned.
    localparam int IW = WIDTH - k * SEG;

    logic [IW-1:0]          w_pa;
    logic [IW-1:0]          w_pb;
    logic                   w_pc;
    logic                   w_pv;
    logic [SEG:0]           w_seg;
    logic [(k+1)*SEG-1:0]   w_ns;
    logic [(k+1)*SEG-1:0]   r_s;
    logic                   r_c;
    logic                   r_v;

    if (k == 0) begin : g_in
      assign w_pa = a;
      assign w_pb = w_bb;
      assign w_pc = w_c0;
      assign w_pv = in_valid;
      assign w_ns = w_seg[SEG-1:0];
    end else begin : g_in
      assign w_pa = g_stage[k-1].g_fwd.r_a;
      assign w_pb = g_stage[k-1].g_fwd.r_b;
      assign w_pc = g_stage[k-1].r_c;
      assign w_pv = g_stage[k-1].r_v;
      assign w_ns = {w_seg[SEG-1:0], g_stage[k-1].r_s};
    end

    assign w_seg = {1'b0, w_pa[SEG-1:0]} + {1'b0, w_pb[SEG-1:0]} + (SEG+1)'(w_pc);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_pv;
        r_s <= w_ns;
        r_c <= w_seg[SEG];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SEG-1:0] r_a;
      logic [IW-SEG-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_pa[IW-1:SEG];
          r_b <= w_pb[IW-1:SEG];
        end
      end
    end else begin : g_last
      logic w_c1;
      logic r_c1;
      logic r_ovf;

      // Carry into the MSB recovered from the MSB sum bit and its operand bits.
      assign w_c1 = w_seg[SEG-1] ^ w_pa[SEG-1] ^ w_pb[SEG-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_c1  <= 1'b0;
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_c1  <= w_c1;
          r_ovf <= w_seg[SEG] ^ w_c1;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign cout_1    = g_stage[STAGES-1].g_last.r_c1;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases on a 32/4 instance, random sweep on
// 16-bit instances with STAGES = 1, 2, 4, 16 against an arithmetic reference.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic        cout, cout_1, ovf;
  logic [31:0] a, b, s;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .cout_1(cout_1), .ovf(ovf)
  );

  logic             sw_v, sw_cin, sw_sub;
  logic [15:0]      sw_a, sw_b;
  logic [3:0]       sw_ir, sw_ov, sw_co, sw_c1, sw_of;
  logic [3:0][15:0] sw_s;

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(sw_ir[0]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[0]), .out_ready(1'b1),
    .s(sw_s[0]), .cout(sw_co[0]), .cout_1(sw_c1[0]), .ovf(sw_of[0])
  );
  pipelined_addsub #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(sw_ir[1]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[1]), .out_ready(1'b1),
    .s(sw_s[1]), .cout(sw_co[1]), .cout_1(sw_c1[1]), .ovf(sw_of[1])
  );
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(sw_ir[2]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[2]), .out_ready(1'b1),
    .s(sw_s[2]), .cout(sw_co[2]), .cout_1(sw_c1[2]), .ovf(sw_of[2])
  );
  pipelined_addsub #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(sw_ir[3]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[3]), .out_ready(1'b1),
    .s(sw_s[3]), .cout(sw_co[3]), .cout_1(sw_c1[3]), .ovf(sw_of[3])
  );

  // Reference: {cout, cout_1, ovf, s} from exact unsigned and signed arithmetic.
  function automatic logic [34:0] model(input int w, input logic [31:0] a_, input logic [31:0] b_,
                                        input logic ci, input logic sb);
    longint unsigned ua, ub, ur, full, half;
    longint          sa, sbv, sr;
    logic            co, c1, ov;
    ua   = longint'(a_);
    ub   = longint'(b_);
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    if (sb) begin
      ur = ua - ub - longint'(ci);
      co = (ua >= ub + longint'(ci));
    end else begin
      ur = ua + ub + longint'(ci);
      co = ur[w];
    end
    ur  = ur & (full - 1);
    sa  = (ua >= half) ? longint'(ua) - longint'(full) : longint'(ua);
    sbv = (ub >= half) ? longint'(ub) - longint'(full) : longint'(ub);
    sr  = sb ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
    ov  = (sr >= longint'(half)) || (sr < -longint'(half));
    c1  = ov ^ co;
    return {co, c1, ov, ur[31:0]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // One isolated operation on the 32/4 instance; checks latency, spec value and model.
  task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                    input logic tc, input logic ts, input logic [34:0] exp);
    int n;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk({tag, "_result"}, {29'b0, cout, cout_1, ovf, s}, {29'b0, exp});
    chk({tag, "_model"}, {29'b0, cout, cout_1, ovf, s}, {29'b0, model(32, ta, tb, tc, ts)});
    step;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_v = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    step;
    step;
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_flags", {61'b0, cout, cout_1, ovf}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    step;

    op("add_basic",  32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {3'b000, 32'h0000_0003});
    op("carry_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {3'b110, 32'h0000_0000});
    op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {3'b011, 32'h8000_0000});
    op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, {3'b000, 32'hFFFF_FFFE});
    op("sub_cin",    32'd7, 32'd5, 1'b1, 1'b1, {3'b110, 32'h0000_0001});

    begin : backpressure
      logic [31:0] exp_q[$];
      logic [31:0] held;
      int          idx, got, stall;
      bit          first;
      idx = 0; got = 0; stall = 0; first = 1'b0; held = '0;
      for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
        out_ready = (stall == 0);
        if (idx < 8) begin
          in_valid = 1'b1; a = 32'(idx); b = 32'(idx); cin = 1'b0; sub = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (!out_ready) begin
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_valid_held", 64'(out_valid), 64'd1);
          if (stall == 3) held = s;
          else chk("bp_s_stable", 64'(s), 64'(held));
          stall--;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("bp_extra_result", 64'd1, 64'd0);
          else chk($sformatf("bp_result%0d", got), 64'(s), 64'(exp_q.pop_front()));
          got++;
          if (!first) begin
            first = 1'b1;
            stall = 3;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(32'(2 * idx));
          idx++;
        end
        step;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", 64'(got), 64'd8);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 6; i++) step;
    end

    begin : reset_midstream
      bit stale;
      stale = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1; a = 32'(10 + i); b = 32'd1; cin = 1'b0; sub = 1'b0;
        step;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 10; i++) begin
        if (out_valid) stale = 1'b1;
        step;
      end
      chk("rst_mid_no_stale", 64'(stale), 64'd0);
      op("post_reset", 32'd100, 32'd23, 1'b1, 1'b0, {3'b000, 32'd124});
    end

    begin : sweep
      logic        hv[2200];
      logic [15:0] ha[2200];
      logic [15:0] hb[2200];
      logic        hc[2200];
      logic        hs[2200];
      int          stg[4];
      int          nacc, drain;
      logic [34:0] e;
      stg = '{1, 2, 4, 16};
      nacc = 0; drain = 0;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
      for (int c = 0; c < 2200; c++) begin
        chk("sw_in_ready", 64'(sw_ir), 64'hF);
        for (int k = 0; k < 4; k++) begin
          if (c >= stg[k] && hv[c - stg[k]]) begin
            chk($sformatf("sw_valid_st%0d_c%0d", stg[k], c), 64'(sw_ov[k]), 64'd1);
            e = model(16, {16'b0, ha[c - stg[k]]}, {16'b0, hb[c - stg[k]]},
                      hc[c - stg[k]], hs[c - stg[k]]);
            chk($sformatf("sw_result_st%0d_c%0d", stg[k], c),
                {29'b0, sw_co[k], sw_c1[k], sw_of[k], 16'b0, sw_s[k]}, {29'b0, e});
          end else begin
            chk($sformatf("sw_idle_st%0d_c%0d", stg[k], c), 64'(sw_ov[k]), 64'd0);
          end
        end
        if (nacc < 1000) begin
          sw_v   = ($urandom_range(0, 3) != 0);
          sw_a   = 16'($urandom);
          sw_b   = 16'($urandom);
          sw_cin = 1'($urandom);
          sw_sub = 1'($urandom);
        end else begin
          sw_v = 1'b0;
          drain++;
        end
        hv[c] = sw_v; ha[c] = sw_a; hb[c] = sw_b; hc[c] = sw_cin; hs[c] = sw_sub;
        if (sw_v) nacc++;
        if (drain > 20) break;
        step;
      end
      chk("sw_accept_count", 64'(nacc), 64'd1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
